// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Producer side of the fetch/decode boundary. Owns the PC, issues one
// instruction-memory read at a time and presents each fetched word together
// with its PC+increment to the F/D register through a valid/ready handshake.
// Execute-stage redirects reload the PC and squash any in-flight fetch.
//
// Parameters:
//   ADDR_W    width of imem_addr (imem_addr = pc[ADDR_W-1:0])
//   RESET_PC  PC loaded on reset
//   PC_INC    PC increment per instruction (word-addressed memory)
//
// Ports:
//   clock            single clock, rising edge
//   reset            synchronous, active-high
//   imem_req         one-cycle read request pulse
//   imem_addr        read address, meaningful only while imem_req=1
//   imem_rvalid      read data valid, exactly one per request
//   imem_rdata       instruction word, sampled when imem_rvalid=1
//   out_valid        out_IR/out_PC_next hold an instruction for decode
//   fd_ready         decode accepts; transfer when out_valid & fd_ready
//   out_IR           fetched instruction
//   out_PC_next      fetch PC + PC_INC
//   redirect         branch/jump taken
//   redirect_target  new PC when redirect=1
//   fetch_count      instructions delivered   (FETCH_PERF_CNT_EN only)
//   squash_count     fetches discarded        (FETCH_PERF_CNT_EN only)
//
// Optional feature: define FETCH_PERF_CNT_EN to build the two performance
// counters. Without it both counter ports read 32'h0 and no flops are built.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              fd_ready,
  output logic [31:0]       out_IR,
  output logic [31:0]       out_PC_next,
  input  logic              redirect,
  input  logic [31:0]       redirect_target,
  output logic [31:0]       fetch_count,
  output logic [31:0]       squash_count
);

  // REQ : about to issue a read for pc_reg
  // WAIT: one read outstanding, waiting for imem_rvalid
  // HOLD: instruction presented to decode, waiting for fd_ready
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        squash_reg, squash_next;
  logic        out_valid_reg, out_valid_next;
  logic [31:0] out_ir_reg, out_ir_next;
  logic [31:0] out_pc_next_reg, out_pc_next_next;

  logic [31:0] pc_plus_inc;
  logic        req_issue;
  logic        transfer_done;   // instruction handed to decode this cycle
  logic        fetch_dropped;   // fetched instruction thrown away this cycle

  assign pc_plus_inc = pc_reg + PC_INC;   // wraps modulo 2^32

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    squash_next      = squash_reg;
    out_valid_next   = out_valid_reg;
    out_ir_next      = out_ir_reg;
    out_pc_next_next = out_pc_next_reg;
    req_issue        = 1'b0;
    transfer_done    = 1'b0;
    fetch_dropped    = 1'b0;

    case (state_reg)
      ST_REQ: begin
        // A redirect this cycle would make pc_reg stale, so hold the request
        // back and issue from the new target next cycle.
        if (!redirect) begin
          req_issue  = 1'b1;
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (imem_rvalid) begin
          state_next  = ST_REQ;
          squash_next = 1'b0;
          if (squash_reg) begin
            // Response belongs to a fetch killed by an earlier redirect.
            fetch_dropped = 1'b1;
          end else if (!redirect) begin
            out_ir_next      = imem_rdata;
            out_pc_next_next = pc_plus_inc;
            pc_next          = pc_plus_inc;
            out_valid_next   = 1'b1;
            state_next       = ST_HOLD;
          end
          // rvalid together with a fresh redirect: data is simply not used.
        end else if (redirect) begin
          // Response still in flight; remember to discard it on arrival so
          // only one request is ever outstanding.
          squash_next = 1'b1;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          // Redirect wins over a simultaneous fd_ready: no transfer.
          fetch_dropped = 1'b1;
          state_next    = ST_REQ;
        end else if (fd_ready) begin
          transfer_done  = 1'b1;
          out_valid_next = 1'b0;
          state_next     = ST_REQ;
        end
      end

      default: begin
        state_next = ST_REQ;
      end
    endcase

    // Redirect overrides the PC and clears the presented instruction in
    // every state; out_IR/out_PC_next keep their stale values.
    if (redirect) begin
      pc_next        = redirect_target;
      out_valid_next = 1'b0;
    end
  end

  assign imem_req    = req_issue & ~reset;
  assign imem_addr   = pc_reg[ADDR_W-1:0];
  assign out_valid   = out_valid_reg;
  assign out_IR      = out_ir_reg;
  assign out_PC_next = out_pc_next_reg;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_REQ;
      pc_reg          <= RESET_PC;
      squash_reg      <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_ir_reg      <= 32'h0;
      out_pc_next_reg <= 32'h0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      squash_reg      <= squash_next;
      out_valid_reg   <= out_valid_next;
      out_ir_reg      <= out_ir_next;
      out_pc_next_reg <= out_pc_next_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_reg;
  logic [31:0] squash_count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count_reg  <= 32'h0;
      squash_count_reg <= 32'h0;
    end else begin
      if (transfer_done) begin
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
      if (fetch_dropped) begin
        squash_count_reg <= squash_count_reg + 32'd1;
      end
    end
  end

  assign fetch_count  = fetch_count_reg;
  assign squash_count = squash_count_reg;
`else
  // Event strobes have no consumer in this build.
  logic unused_events;
  assign unused_events = transfer_done ^ fetch_dropped;

  assign fetch_count  = 32'h0;
  assign squash_count = 32'h0;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Producer side of the fetch/decode pipeline boundary.
- Owns the PC and issues one instruction-memory read at a time.
- Presents each fetched instruction word and its PC+increment to the F/D pipeline register with a valid/ready handshake.
- Handles decode-side stalls (ready low) and branch/jump redirects from execute, squashing any in-flight fetch.

Parameters:
ADDR_W, 12, width of imem_addr; imem_addr = pc[ADDR_W-1:0]
RESET_PC, 32'h00000000, PC value loaded on reset
PC_INC, 32'd1, PC increment per instruction (word-addressed memory)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
imem_req  output  1  one-cycle read request pulse
imem_addr  output  ADDR_W  read address, meaningful only while imem_req=1
imem_rvalid  input  1  read data valid; exactly one per request, at least 1 cycle after it
imem_rdata  input  32  instruction word, sampled when imem_rvalid=1
out_valid  output  1  out_IR/out_PC_next hold an instruction for decode
fd_ready  input  1  F/D register write enable; transfer occurs when out_valid & fd_ready
out_IR  output  32  fetched instruction
out_PC_next  output  32  fetch PC + PC_INC
redirect  input  1  branch/jump taken
redirect_target  input  32  new PC when redirect=1
fetch_count  output  32  instructions delivered (optional feature)
squash_count  output  32  fetches discarded (optional feature)

Behaviour:
- Reset is synchronous and active-high, on clock rising edge.
  - pc=RESET_PC, state=REQ, squash=0, out_valid=0, out_IR=0, out_PC_next=0, counters=0.
  - imem_req=0 in any cycle where reset=1.
- States: REQ, WAIT, HOLD. All registers update on rising clock.
- REQ:
  - imem_req = !redirect (combinational); imem_addr = pc[ADDR_W-1:0].
  - If a request is issued, go to WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with squash=0: out_IR<=imem_rdata, out_PC_next<=pc+PC_INC (mod 2^32), pc<=pc+PC_INC, out_valid<=1, go to HOLD.
  - On imem_rvalid with squash=1: discard data, squash<=0, go to REQ.
- HOLD:
  - out_valid=1; out_IR and out_PC_next stable while fd_ready=0 (stall of any length).
  - When fd_ready=1, the transfer completes that cycle; out_valid<=0, go to REQ.
- Redirect priority: reset > redirect > normal. When redirect=1:
  - pc<=redirect_target and out_valid<=0 in every state.
  - REQ: request suppressed; stay in REQ.
  - WAIT, imem_rvalid=0: squash<=1; stay in WAIT. The outstanding response is dropped on arrival.
  - WAIT, imem_rvalid=1: response dropped; go to REQ, squash<=0.
  - HOLD: held instruction dropped even if fd_ready=1; no transfer counted; go to REQ.
- Only one outstanding memory request at any time. Minimum 3 cycles per instruction (REQ, WAIT, HOLD) at memory latency 1.
- out_IR and out_PC_next retain their last values when out_valid=0. Decode ignores them.
- PC wraps modulo 2^32; imem_addr is truncated to ADDR_W bits.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - fetch_count increments by 1 on each completed transfer (out_valid & fd_ready & !redirect).
  - squash_count increments by 1 on each dropped fetch: a held instruction discarded by redirect, or a response discarded under squash.
  - Both counters are 32-bit, wrap, and reset to 0.
- Not defined: both ports are tied to 32'h0 and no counter flops are built.

Test Plan:
- Reset, then memory latency 1 returns 32'hAAAA0001 at addr 0 → imem_req in the first cycle after reset deasserts, addr 0. out_valid=1 with out_IR=32'hAAAA0001, out_PC_next=1. Next request at addr 1 after the handshake.
- fd_ready=0 for 5 cycles while in HOLD → out_valid, out_IR, out_PC_next stable; no imem_req. fd_ready=1 → transfer, then request at next PC.
- Redirect to 32'h40 while in WAIT (latency 3) → in-flight response dropped, out_valid stays 0. Next request addr 12'h040; delivered out_PC_next=32'h41. squash_count=1 with FETCH_PERF_CNT_EN.
- Redirect coinciding with imem_rvalid → data not presented; next request at redirect_target.
- Redirect in HOLD with fd_ready=1 → no transfer, out_valid=0 next cycle, fetch_count unchanged.
- RESET_PC=32'hFFFFFFFF, PC_INC=1 → out_PC_next=32'h0; next imem_addr=0. Reset asserted mid-WAIT → state REQ, out_valid=0, late rvalid ignored.
